// File: rtl/raisin64_mem_pkg.sv
// Shared types for the single-port memory arbiter.
//   owner_t : which port owns the response slot in the next cycle
//   W64..W8 : RAM access-width encodings (the same encoding the ram block uses)
//   grant_t : one-hot grant returned by the winner picker
package raisin64_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_DBG  = 2'd3
  } owner_t;

  localparam logic [1:0] W64 = 2'b00;
  localparam logic [1:0] W32 = 2'b01;
  localparam logic [1:0] W16 = 2'b10;
  localparam logic [1:0] W8  = 2'b11;

  typedef struct packed {
    logic ifetch;
    logic data;
    logic dbg;
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
//   en       : arbitration enable (low forces no grant, used during reset)
//   if_req   : ifetch request
//   d_req    : data request (read or write)
//   dbg_req  : debug request
//   dbg_halt : debug owns memory; CPU ports are locked out
//   starved  : ifetch has waited the maximum number of data grants
//   gnt      : one-hot grant (all zero when nobody wins)
module mem_arb_pick
  import raisin64_mem_pkg::*;
(
  input  logic   en,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   dbg_req,
  input  logic   dbg_halt,
  input  logic   starved,
  output grant_t gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      if (dbg_halt)
        gnt.dbg = dbg_req;
      // data normally wins; ifetch wins when idle data or once starved
      else if (if_req && (starved || !d_req))
        gnt.ifetch = 1'b1;
      else if (d_req)
        gnt.data = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM between ifetch, data and debug ports.
// Grants and the RAM drive are combinational in the request cycle; the
// response pulse for the winner comes one cycle later, alongside mem_rdata.
//   if_*   : instruction fetch request / grant / response
//   d_*    : data read/write request / grant / completion
//   dbg_*  : debug request (only while dbg_halt) / grant / completion
//   mem_*  : single RAM port; mem_rdata valid one cycle after mem_cs
module mem_arbiter
  import raisin64_mem_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              d_rstrobe,
  input  logic              d_wstrobe,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_width,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  input  logic              dbg_halt,
  input  logic              dbg_ce,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [1:0]        mem_width,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             d_req;
  grant_t           gnt;

  assign d_req   = d_rstrobe | d_wstrobe;
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // rst_n gates the grant so nothing reaches the RAM while in reset
  mem_arb_pick u_pick (
    .en       (rst_n),
    .if_req   (if_req),
    .d_req    (d_req),
    .dbg_req  (dbg_ce),
    .dbg_halt (dbg_halt),
    .starved  (starved),
    .gnt      (gnt)
  );

  assign if_gnt  = gnt.ifetch;
  assign d_gnt   = gnt.data;
  assign dbg_gnt = gnt.dbg;

  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_width = W64;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt.ifetch) begin
      mem_cs   = 1'b1;
      mem_addr = if_addr;
    end else if (gnt.data) begin
      mem_cs    = 1'b1;
      mem_we    = d_wstrobe;  // both strobes high counts as a write
      mem_width = d_width;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (gnt.dbg) begin
      mem_cs    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      if (gnt.ifetch)    owner <= OWN_IF;
      else if (gnt.data) owner <= OWN_D;
      else if (gnt.dbg)  owner <= OWN_DBG;
      else               owner <= OWN_NONE;

      if (!if_req || gnt.ifetch)
        starve_cnt <= '0;
      else if (gnt.data && !starved)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // owner is the registered record of the grant, so these are registered pulses
  assign if_rvalid  = (owner == OWN_IF);
  assign d_done     = (owner == OWN_D);
  assign dbg_rvalid = (owner == OWN_DBG);

  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import raisin64_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 0, d_rstrobe = 0, d_wstrobe = 0;
  logic        dbg_halt = 0, dbg_ce = 0, dbg_we = 0;
  logic [63:0] if_addr = 0, d_addr = 0, d_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic [1:0]  d_width = W64;
  logic        if_gnt, if_rvalid, d_gnt, d_done, dbg_gnt, dbg_rvalid;
  logic [63:0] if_rdata, d_rdata, dbg_rdata;
  logic        mem_cs, mem_we;
  logic [1:0]  mem_width;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = 0;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [2:0]  port;  // {if, d, dbg}
    logic [63:0] data;
    bit          chk;
    int          due;
  } exp_t;
  exp_t sb[$];

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .d_rstrobe(d_rstrobe), .d_wstrobe(d_wstrobe), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_width(d_width), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done),
    .dbg_halt(dbg_halt), .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: unwritten locations read as DEAD in the top half and the address below
  logic [63:0] ram [logic [63:0]];
  function automatic logic [63:0] rd(input logic [63:0] a);
    return ram.exists(a) ? ram[a] : (64'hDEAD_0000_0000_0000 | a);
  endfunction
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        logic [63:0] v;
        v = rd(mem_addr);
        case (mem_width)
          W64: v = mem_wdata;
          W32: v[31:0] = mem_wdata[31:0];
          W16: v[15:0] = mem_wdata[15:0];
          default: v[7:0] = mem_wdata[7:0];
        endcase
        ram[mem_addr] = v;
      end else begin
        mem_rdata <= rd(mem_addr);
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // response monitor: pops the scoreboard whenever a completion pulse appears
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missing_resp cyc=%0d got=none want_port=%b", cyc, sb[0].port);
        void'(sb.pop_front());
      end
      if (if_rvalid || d_done || dbg_rvalid) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          checks++; errors++;
          $display("FAIL unexpected_resp cyc=%0d got=%b want=none", cyc, {if_rvalid, d_done, dbg_rvalid});
        end else begin
          exp_t e;
          e = sb.pop_front();
          cmp("resp_port", {61'd0, if_rvalid, d_done, dbg_rvalid}, {61'd0, e.port});
          if (e.chk)
            cmp("resp_data", e.port[2] ? if_rdata : e.port[1] ? d_rdata : dbg_rdata, e.data);
        end
      end
    end
  end

  // one cycle: inputs already driven; check grant and RAM drive, queue the response
  task automatic tick(input logic [2:0] eg, input logic [63:0] ea, input logic ewe,
                      input logic [1:0] ew, input logic [63:0] ewd,
                      input logic [63:0] erd, input bit chk, input bit push);
    @(negedge clk);
    cmp("grant", {61'd0, if_gnt, d_gnt, dbg_gnt}, {61'd0, eg});
    if (eg != 3'b000) begin
      cmp("mem_ctl", {61'd0, mem_cs, mem_we, 1'b0}, {61'd0, 1'b1, ewe, 1'b0});
      cmp("mem_width", {62'd0, mem_width}, {62'd0, ew});
      cmp("mem_addr", mem_addr, ea);
      if (ewe) cmp("mem_wdata", mem_wdata, ewd);
      if (push) sb.push_back('{port: eg, data: erd, chk: chk, due: cyc + 1});
    end else begin
      cmp("idle_ctl", {62'd0, mem_cs, mem_we}, 64'd0);
      cmp("idle_addr", mem_addr, 64'd0);
      cmp("idle_wdata", mem_wdata, 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // reset with requests pending: nothing may be granted or pulse
    if_req = 1; if_addr = 64'h10; d_rstrobe = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset_outs", {58'd0, if_gnt, d_gnt, dbg_gnt, if_rvalid, d_done, dbg_rvalid}, 64'd0);
    cmp("reset_mem", {62'd0, mem_cs, mem_we}, 64'd0);
    if_req = 0; d_rstrobe = 0;
    @(posedge clk); #1; rst_n = 1;
    tick(3'b000, 0, 0, W64, 0, 0, 0, 0);

    // ifetch back-to-back
    if_req = 1; if_addr = 64'h10;
    tick(3'b100, 64'h10, 0, W64, 0, 64'hDEAD_0000_0000_0010, 1, 1);
    if_addr = 64'h18;
    tick(3'b100, 64'h18, 0, W64, 0, 64'hDEAD_0000_0000_0018, 1, 1);
    if_req = 0;
    tick(3'b000, 0, 0, W64, 0, 0, 0, 0);

    // starvation guard: D,D,D,D,IF twice
    if_req = 1; if_addr = 64'h40; d_rstrobe = 1; d_addr = 64'h80;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) tick(3'b100, 64'h40, 0, W64, 0, 64'hDEAD_0000_0000_0040, 1, 1);
      else            tick(3'b010, 64'h80, 0, W64, 0, 64'hDEAD_0000_0000_0080, 1, 1);
    end
    if_req = 0; d_rstrobe = 0;
    tick(3'b000, 0, 0, W64, 0, 0, 0, 0);

    // byte write then read back
    d_wstrobe = 1; d_addr = 64'h21; d_wdata = 64'h1234_5678_9ABC_DEAB; d_width = W8;
    tick(3'b010, 64'h21, 1, W8, 64'h1234_5678_9ABC_DEAB, 0, 0, 1);
    d_wstrobe = 0; d_rstrobe = 1;
    tick(3'b010, 64'h21, 0, W8, 0, 64'hDEAD_0000_0000_00AB, 1, 1);
    // both strobes high is a write
    d_wstrobe = 1; d_addr = 64'h30; d_wdata = 64'hCAFE_0000_0000_0055; d_width = W64;
    tick(3'b010, 64'h30, 1, W64, 64'hCAFE_0000_0000_0055, 0, 0, 1);
    d_wstrobe = 0;
    tick(3'b010, 64'h30, 0, W64, 0, 64'hCAFE_0000_0000_0055, 1, 1);

    // halt rises behind an in-flight data read
    d_addr = 64'h80;
    tick(3'b010, 64'h80, 0, W64, 0, 64'hDEAD_0000_0000_0080, 1, 1);
    dbg_halt = 1;
    tick(3'b000, 0, 0, W64, 0, 0, 0, 0);
    dbg_ce = 1; dbg_addr = 64'h10;
    tick(3'b001, 64'h10, 0, W64, 0, 64'hDEAD_0000_0000_0010, 1, 1);
    dbg_we = 1; dbg_addr = 64'h48; dbg_wdata = 64'h7777_0000_0000_0077;
    tick(3'b001, 64'h48, 1, W64, 64'h7777_0000_0000_0077, 0, 0, 1);
    dbg_ce = 0; dbg_we = 0; dbg_halt = 0; d_addr = 64'h48;
    tick(3'b010, 64'h48, 0, W64, 0, 64'h7777_0000_0000_0077, 1, 1);
    d_rstrobe = 0;
    tick(3'b000, 0, 0, W64, 0, 0, 0, 0);

    // debug request without halt is ignored and does not touch the RAM
    dbg_ce = 1; dbg_we = 1; dbg_addr = 64'h50; dbg_wdata = 64'h1;
    tick(3'b000, 0, 0, W64, 0, 0, 0, 0);
    dbg_ce = 0; dbg_we = 0; d_rstrobe = 1; d_addr = 64'h50;
    tick(3'b010, 64'h50, 0, W64, 0, 64'hDEAD_0000_0000_0050, 1, 1);
    d_rstrobe = 0;
    tick(3'b000, 0, 0, W64, 0, 0, 0, 0);

    // reset right after an ifetch grant drops its response
    if_req = 1; if_addr = 64'h10;
    tick(3'b100, 64'h10, 0, W64, 0, 0, 0, 0);
    if_req = 0; rst_n = 0;
    @(negedge clk);
    cmp("rst_drop", {61'd0, if_rvalid, d_done, dbg_rvalid}, 64'd0);
    @(posedge clk); #1; rst_n = 1;
    repeat (3) tick(3'b000, 0, 0, W64, 0, 0, 0, 0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty got=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one synchronous RAM between the pipeline's instruction-fetch port, its data port, and the JTAG debug port. It sits between `pipeline`/`debug_control` and a single `ram` instance, replacing the separate imem/dmem muxing. It provides per-port valid/ready request handshakes, fixed-latency responses, debug-halt ownership and an ifetch starvation guard.

## Interface
- `ADDR_W`, default 64: address width on all ports.
- `DATA_W`, default 64: data width on all ports.
- `STARVE_LIMIT`, default 4, legal range ≥1: consecutive data grants tolerated while ifetch waits.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rdata`  out  DATA_W  fetch data
- `if_rvalid`  out  1  fetch data valid (1-cycle pulse)
- `d_rstrobe`, `d_wstrobe`  in  1 each  data read / write request
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  data write value
- `d_width`  in  2  data access width (RAM encoding)
- `d_gnt`  out  1  data accepted this cycle
- `d_rdata`  out  DATA_W  data read value
- `d_done`  out  1  data access complete (read or write), 1-cycle pulse
- `dbg_halt`  in  1  debug owns memory
- `dbg_ce`, `dbg_we`  in  1 each  debug request / write qualifier
- `dbg_addr`  in  ADDR_W  debug address
- `dbg_wdata`  in  DATA_W  debug write value
- `dbg_gnt`  out  1  debug accepted
- `dbg_rdata`  out  DATA_W  debug read value
- `dbg_rvalid`  out  1  debug access complete pulse
- `mem_cs`, `mem_we`  out  1 each  RAM select / write
- `mem_width`  out  2  RAM write width
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after `mem_cs`

## Operation
- Request accepted when request and its `*_gnt` are both high in the same cycle. The requester may change or drop its request in the next cycle, so back-to-back requests are legal.
- At most one grant per cycle. Winner selection:
  - `dbg_halt`=1: only debug eligible.
  - `dbg_halt`=0: debug never granted; data beats ifetch, except when `starve_cnt`==`STARVE_LIMIT` and `if_req` is high, in which case ifetch wins.
- `starve_cnt`:
  - +1 when data is granted while `if_req` is high.
  - Cleared on an ifetch grant or whenever `if_req`=0.
  - Saturates at `STARVE_LIMIT`.
- The winner drives `mem_*` combinationally in the grant cycle. `mem_cs`=1 and `mem_we` equals the write qualifier. `mem_width` is `d_width` for data and 2'b00 for ifetch and debug.
- With no grant: `mem_cs`=0, `mem_we`=0, `mem_addr` and `mem_wdata` hold 0.
- `d_rstrobe` and `d_wstrobe` both high is treated as a write.
- `owner` register (NONE/IF/D/DBG) records the grant and routes the next-cycle response. Only the owner's valid/done pulses. `*_rdata` pass `mem_rdata` through for all ports; they are meaningful only with the pulse. A write also gets a completion pulse.
- `dbg_halt` rising while a CPU access is in flight: the in-flight response is still delivered to its original owner. New CPU requests wait until `dbg_halt` falls.
- Reset: all `*_gnt`, `*_rvalid`, `d_done`, `mem_cs`, `mem_we` = 0; `owner`=NONE; `starve_cnt`=0. Reset mid-access drops the pending response.

## Timing
- Grant and `mem_*` drive are combinational in cycle N. The response pulse is registered in N+1, with data from `mem_rdata` the same cycle.
- Latency request→response is 1 cycle when uncontended. Sustained throughput is 1 access/cycle.
- The `owner` and `starve_cnt` update on the same edge as the RAM sample.

## Structure
- Package `raisin64_mem_pkg`:
  - `owner_t` enum (`OWN_NONE`, `OWN_IF`, `OWN_D`, `OWN_DBG`).
  - Width encodings `W64`, `W32`, `W16`, `W8` matching `ram`.
- Sub-module `mem_arb_pick`: combinational winner select from requests, `dbg_halt` and the starvation flag. Returns a one-hot grant.
- `mem_arbiter` holds `owner`, `starve_cnt`, output muxing and response routing.

## Test plan
- Reset then `if_req`, `if_addr`=0x10 held → `if_gnt` in cycle 0, `mem_addr`=0x10, `if_rvalid` in cycle 1 with `mem_rdata`; all outputs 0 during reset.
- `if_req` and `d_rstrobe` continuously high, `STARVE_LIMIT`=4 → grants D,D,D,D,IF repeating; `starve_cnt` returns to 0 after each IF grant.
- Data write `d_width`=W8 to 0x21, value 0xAB, then read back → `mem_width`=W8 on the write; `d_done` after the write; `d_rdata` byte 0xAB after the read.
- `dbg_halt` rises in the same cycle as a data grant → `d_done` still pulses in N+1. Subsequent `d_rstrobe` gets no grant until halt falls; debug read granted meanwhile and `dbg_rvalid` pulses.
- `dbg_ce`=1 with `dbg_halt`=0 → `dbg_gnt` stays 0 and the RAM is untouched.
- `rst_n` asserted in the cycle after an ifetch grant → no `if_rvalid`; `owner`=NONE after release.
